// File: rtl/soc_uart_tx_arbiter.sv
// Round-robin arbiter with per-packet grant locking that shares one 8N1 UART TX line between NUM_REQ byte streams.
// Optional idle-lock timeout is compiled in with `define SOC_UART_TX_ARB_TIMEOUT_EN.
module soc_uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DIV_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DIV_W-1:0]           clk_div,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       sout,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_lock;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_grant;
  logic [7:0]       r_shift;
  logic             r_last;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;

  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic             w_accept;
  logic             w_bit_end;
  logic [DIV_W-1:0] w_div_eff;
  logic [7:0]       w_byte;

  function automatic logic [IDW-1:0] f_wrap(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IDW-1:0];
  endfunction

  // Handshake: a byte moves when req_valid[i] && req_ready[i] in the same cycle; ready is only
  // raised for the eligible winner while IDLE, and requesters hold data stable until then.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_grant;
    if (r_lock) begin
      w_found = req_valid[r_grant];
    end else begin
      // Walk from the far end so the requester nearest the pointer overwrites last.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid[f_wrap(r_ptr, i)]) begin
          w_found = 1'b1;
          w_win   = f_wrap(r_ptr, i);
        end
      end
    end
  end

  assign w_accept  = (r_state == S_IDLE) && w_found;
  assign w_bit_end = (r_cnt == '0);
  assign w_div_eff = (clk_div < DIV_W'(2)) ? DIV_W'(2) : clk_div;
  assign w_byte    = req_data[{w_win, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_START;
      S_START: if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
      S_STOP:  if (w_bit_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    sout      = 1'b1;
    if (w_accept) req_ready = NUM_REQ'(1) << w_win;
    case (r_state)
      S_START: sout = 1'b0;
      S_DATA:  sout = r_shift[r_bit_idx];
      default: sout = 1'b1;
    endcase
    busy = (r_state != S_IDLE) || r_lock;
  end

  assign grant_id = r_grant;

  // Frame datapath: byte, last flag and bit period are frozen at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_last    <= 1'b0;
      r_div     <= DIV_W'(2);
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_grant   <= '0;
    end else if (w_accept) begin
      r_shift   <= w_byte;
      r_last    <= req_last[w_win];
      r_div     <= w_div_eff;
      r_cnt     <= w_div_eff - 1'b1;
      r_bit_idx <= '0;
      r_grant   <= w_win;
    end else if (r_state != S_IDLE) begin
      r_cnt <= w_bit_end ? (r_div - 1'b1) : (r_cnt - 1'b1);
      if ((r_state == S_DATA) && w_bit_end) r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

`ifdef SOC_UART_TX_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_run;
  logic            w_to_fire;

  assign w_to_run  = (r_state == S_IDLE) && r_lock && !req_valid[r_grant];
  assign w_to_fire = w_to_run && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_to_cnt <= '0;
    else if (w_accept || !r_lock || w_to_fire) r_to_cnt <= '0;
    else if (w_to_run)                         r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // The pointer only moves when a packet ends (or a stalled lock is abandoned).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= 1'b0;
      r_ptr  <= '0;
    end else if ((r_state == S_STOP) && w_bit_end) begin
      r_lock <= ~r_last;
      if (r_last) r_ptr <= f_wrap(r_grant, 1);
    end
`ifdef SOC_UART_TX_ARB_TIMEOUT_EN
    else if (w_to_fire) begin
      r_lock <= 1'b0;
      r_ptr  <= f_wrap(r_grant, 1);
    end
`endif
  end

endmodule

// File: tb/tb_soc_uart_tx_arbiter.sv
// Bench for soc_uart_tx_arbiter: per-requester byte sources, accept monitor and a UART frame
// decoder checked against expected grant/byte/bit-period queues.
module tb_soc_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] clk_div;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        sout;
  logic        busy;
  logic [1:0]  grant_id;

  soc_uart_tx_arbiter #(
    .NUM_REQ(4), .DIV_W(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .sout(sout), .busy(busy), .grant_id(grant_id)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  logic [3:0] fired = '0;

  logic [7:0] src_d [4][$];
  logic       src_l [4][$];

  logic [7:0] exp_q[$];
  logic [1:0] exp_id_q[$];
  int         exp_div_q[$];

  typedef struct packed {
    logic [15:0]     div;
    logic [3:0]      mask;
    logic [3:0][7:0] data;
    logic [3:0][1:0] order;
    logic [2:0]      n;
    logic [3:0]      period;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input logic [15:0] div, input logic [3:0] mask,
                         input logic [31:0] data, input logic [7:0] order, input logic [2:0] n,
                         input logic [3:0] period);
    tbl[idx].div    = div;
    tbl[idx].mask   = mask;
    tbl[idx].data   = data;
    tbl[idx].order  = order;
    tbl[idx].n      = n;
    tbl[idx].period = period;
  endtask

  task automatic push_src(input int i, input logic [7:0] d, input logic l);
    src_d[i].push_back(d);
    src_l[i].push_back(l);
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] d, input int p);
    exp_id_q.push_back(id);
    exp_q.push_back(d);
    exp_div_q.push_back(p);
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n;
    n = 0;
    while (acc_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(acc_cnt >= target), 1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_id_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size() + exp_id_q.size()), 0);
    if (exp_q.size() != 0 || exp_id_q.size() != 0) begin
      exp_q.delete();
      exp_id_q.delete();
      exp_div_q.delete();
    end
  endtask

  // driver: present head of each source queue, retire it after a handshake
  initial begin : drv
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (fired[i] && src_d[i].size() > 0) begin
          src_d[i].delete(0);
          src_l[i].delete(0);
        end
        if (src_d[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = src_d[i][0];
          req_last[i]        = src_l[i][0];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // accept monitor: grant order, one-hot ready, grant_id follows the accept
  initial begin : acc_mon
    int   id;
    logic pend;
    logic [1:0] pend_id;
    pend = 1'b0;
    pend_id = '0;
    forever begin
      @(negedge clk);
      fired = req_valid & req_ready;
      if (pend) begin
        chk("grant_id", 32'(grant_id), 32'(pend_id));
        pend = 1'b0;
      end
      if (req_ready != 4'b0) begin
        id = 0;
        for (int i = 0; i < 4; i++) if (req_ready[i]) id = i;
        chk("ready_onehot", {30'd0, $onehot(req_ready), |(req_ready & ~req_valid)}, 32'd2);
        acc_cnt++;
        if (exp_id_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL accept_unexpected got=%0d expected=none", id);
        end else begin
          pend_id = exp_id_q.pop_front();
          chk("grant_order", 32'(id), 32'(pend_id));
          pend = 1'b1;
        end
      end
    end
  end

  // UART decoder: every sample inside a bit must agree, so the bit period is checked too
  initial begin : uart_mon
    int p;
    logic [9:0] bits;
    logic bad;
    logic aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && sout === 1'b0) begin
        if (exp_div_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected got=start expected=idle");
          p = 4;
        end else begin
          p = exp_div_q.pop_front();
        end
        bits = '0;
        bad = 1'b0;
        aborted = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int j = 0; j < p; j++) begin
            if (b != 0 || j != 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (j == 0) bits[b] = sout;
            else if (sout !== bits[b]) bad = 1'b1;
          end
          if (aborted) break;
        end
        if (!aborted) begin
          chk("frame_shape", {29'd0, bad, bits[0], bits[9]}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_data got=%0h expected=none", bits[8:1]);
          end else begin
            chk("frame_data", 32'(bits[8:1]), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin : main
    int base;
    logic [7:0] r0, r2, r3;
    rst_n   = 1'b0;
    clk_div = 16'd4;
    repeat (3) @(negedge clk);
    chk("reset_sout", 32'(sout), 1);
    chk("reset_ready", 32'(req_ready), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_grant_id", 32'(grant_id), 0);
    rst_n = 1'b1;

    r0 = 8'($urandom_range(0, 255));
    r2 = 8'($urandom_range(0, 255));
    r3 = 8'($urandom_range(0, 255));
    // order packs grant k into bits [2k+1:2k]; pointer carries over between rows
    set_vec(0, 16'd4, 4'hF, 32'h13121110,            8'hE4, 3'd4, 4'd4);
    set_vec(1, 16'd4, 4'h1, 32'h000000A5,            8'h00, 3'd1, 4'd4);
    set_vec(2, 16'd0, 4'h4, 32'h003C0000,            8'h02, 3'd1, 4'd2);
    set_vec(3, 16'd1, 4'hA, 32'hC3005A00,            8'h07, 3'd2, 4'd2);
    set_vec(4, 16'd8, 4'h3, 32'h000000FF,            8'h04, 3'd2, 4'd8);
    set_vec(5, 16'd3, 4'hD, {r3, r2, 8'h00, r0},     8'h0E, 3'd3, 4'd3);

    for (int r = 0; r < 6; r++) begin
      clk_div = tbl[r].div;
      for (int i = 0; i < 4; i++)
        if (tbl[r].mask[i]) push_src(i, tbl[r].data[i], 1'b1);
      for (int k = 0; k < int'(tbl[r].n); k++)
        push_exp(tbl[r].order[k], tbl[r].data[tbl[r].order[k]], int'(tbl[r].period));
      wait_drain(3000);
      repeat (2) @(negedge clk);
      chk("busy_after_packet", 32'(busy), 0);
    end

    // clk_div change mid-frame only affects the next frame
    clk_div = 16'd4;
    base = acc_cnt;
    push_src(0, 8'h3A, 1'b1);
    push_src(0, 8'hB7, 1'b1);
    push_exp(2'd0, 8'h3A, 4);
    push_exp(2'd0, 8'hB7, 8);
    wait_acc(base + 1, 200);
    repeat (5) @(negedge clk);
    clk_div = 16'd8;
    wait_drain(3000);

    // locked 3-byte packet from req1 while req2 waits
    clk_div = 16'd4;
    base = acc_cnt;
    push_src(1, 8'hD1, 1'b0);
    push_src(1, 8'hD2, 1'b0);
    push_src(1, 8'hD3, 1'b1);
    push_src(2, 8'h2E, 1'b1);
    push_exp(2'd1, 8'hD1, 4);
    push_exp(2'd1, 8'hD2, 4);
    push_exp(2'd1, 8'hD3, 4);
    push_exp(2'd2, 8'h2E, 4);
    wait_acc(base + 1, 200);
    begin
      int n;
      logic dropped;
      n = 0;
      dropped = 1'b0;
      while (acc_cnt < base + 3 && n < 2000) begin
        @(negedge clk);
        if (busy !== 1'b1) dropped = 1'b1;
        n++;
      end
      chk("busy_locked", 32'(dropped), 0);
    end
    wait_drain(3000);

    // reset during DATA bit 3 of a req3 frame
    base = acc_cnt;
    push_src(3, 8'h77, 1'b1);
    exp_id_q.push_back(2'd3);
    exp_div_q.push_back(4);
    wait_acc(base + 1, 200);
    repeat (18) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_sout", 32'(sout), 1);
    chk("midreset_ready", 32'(req_ready), 0);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_grant_id", 32'(grant_id), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_src(0, 8'h81, 1'b1);
    push_src(3, 8'h18, 1'b1);
    push_exp(2'd0, 8'h81, 4);
    push_exp(2'd3, 8'h18, 4);
    wait_drain(3000);

    // req2 stalls mid-packet; req3 must wait on the lock
    base = acc_cnt;
    push_src(2, 8'h42, 1'b0);
    push_src(3, 8'h99, 1'b1);
    push_exp(2'd2, 8'h42, 4);
`ifdef SOC_UART_TX_ARB_TIMEOUT_EN
    push_exp(2'd3, 8'h99, 4);
    wait_drain(3000);
    chk("timeout_accepts", 32'(acc_cnt), 32'(base + 2));
`else
    wait_drain(3000);
    repeat (100) @(negedge clk);
    chk("lock_hold_accepts", 32'(acc_cnt), 32'(base + 1));
    chk("lock_hold_busy", 32'(busy), 1);
    chk("lock_hold_grant_id", 32'(grant_id), 2);
    chk("lock_hold_sout", 32'(sout), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
